bbox_frame_ctrl: RTL and testbench

//  Per-frame sequencer for the HSV denoise/bounding-box pipeline. Watches the pipeline vsync,

---
 rtl/bbox_ctrl_pkg.sv | 25 ++
 rtl/bbox_frame_ctrl_if.sv | 28 ++
 rtl/bbox_lock_filter.sv | 56 +++++
 rtl/bbox_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bbox_frame_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bbox_ctrl_pkg.sv
// Shared constants, state encoding and box type for the bbox frame controller.
package bbox_ctrl_pkg;

    localparam int COORD_W     = 13;
    localparam int MIN_DIM     = 4;
    localparam int LOCK_FRAMES = 3;
    localparam int LOSS_FRAMES = 5;
    localparam int LINE_WIDTH  = 640;
    localparam int FRAME_LINES = 480;
    localparam int FRAME_AREA  = LINE_WIDTH * FRAME_LINES;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACTIVE  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_PUBLISH = 3'd4;

    typedef struct packed {
        logic [COORD_W-1:0] t;
        logic [COORD_W-1:0] b;
        logic [COORD_W-1:0] l;
        logic [COORD_W-1:0] r;
    } box_t;

endpackage

// File: rtl/bbox_frame_ctrl_if.sv
// Tracker box inputs and the valid/ready result channel of the frame controller.
interface bbox_frame_ctrl_if;

    localparam int CW = bbox_ctrl_pkg::COORD_W;

    logic [CW-1:0] box_t;
    logic [CW-1:0] box_b;
    logic [CW-1:0] box_l;
    logic [CW-1:0] box_r;
    logic [CW-1:0] ctr_row;
    logic [CW-1:0] ctr_col;
    logic [CW-1:0] box_w;
    logic [CW-1:0] box_h;
    logic          locked;
    logic          out_valid;
    logic          out_ready;

    modport master (
        input  box_t, box_b, box_l, box_r, out_ready,
        output ctr_row, ctr_col, box_w, box_h, locked, out_valid
    );

    modport slave (
        output box_t, box_b, box_l, box_r, out_ready,
        input  ctr_row, ctr_col, box_w, box_h, locked, out_valid
    );

endinterface

// File: rtl/bbox_lock_filter.sv
// Lock hysteresis: saturating good/bad frame counters driving a sticky locked flag.
// Updates only on step; locked reflects the counters after that step.
module bbox_lock_filter
    import bbox_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic step,
    input  logic valid,
    output logic locked
);

    localparam int CNT_MAX = (LOCK_FRAMES > LOSS_FRAMES) ? LOCK_FRAMES : LOSS_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GOOD_MAX = CNT_W'(LOCK_FRAMES);
    localparam logic [CNT_W-1:0] BAD_MAX  = CNT_W'(LOSS_FRAMES);

    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] bad_q, bad_d;
    logic             locked_q, locked_d;

    always_comb begin
        good_d   = good_q;
        bad_d    = bad_q;
        locked_d = locked_q;
        if (step) begin
            if (valid) begin
                good_d = (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;
                bad_d  = '0;
            end else begin
                bad_d  = (bad_q == BAD_MAX) ? bad_q : bad_q + 1'b1;
                good_d = '0;
            end
            if (good_d == GOOD_MAX) begin
                locked_d = 1'b1;
            end else if (bad_d == BAD_MAX) begin
                locked_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;

endmodule

// File: rtl/bbox_frame_ctrl.sv
// Per-frame sequencer: samples the tracker box at vsync, validates it and publishes centre/size.
// out_valid rises 4 cycles after vs_n is first sampled low; held until out_ready, later frames dropped.
// BBOX_AUTO_THRESH_EN selects adaptive denoise threshold instead of a registered switch copy.
module bbox_frame_ctrl
    import bbox_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        vs_n,
    input  logic [3:0]  threshold_sw,
    output logic        en_o,
    output logic [3:0]  threshold_o,
    output logic        overrun,
    output logic [15:0] frame_cnt,
    bbox_frame_ctrl_if.master bus
);

    localparam logic [COORD_W-1:0] MIN_DIM_C = COORD_W'(MIN_DIM);

    logic               vs_q, vs_prev_q, fe_q;
    logic [2:0]         state_q, state_d;
    box_t               box_q, box_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               en_q, en_d;
    logic               ovr_q, ovr_d;
    logic               vld_q, vld_d;
    logic [COORD_W-1:0] row_q, row_d, col_q, col_d, w_q, w_d, h_q, h_d;
    logic [COORD_W-1:0] row_ctr, col_ctr, w_raw, h_raw;
    logic               frame_ok, step;
    logic [3:0]         thr_q;

    assign row_ctr  = COORD_W'(({1'b0, box_q.t} + {1'b0, box_q.b}) >> 1);
    assign col_ctr  = COORD_W'(({1'b0, box_q.l} + {1'b0, box_q.r}) >> 1);
    assign w_raw    = box_q.r - box_q.l + COORD_W'(1);
    assign h_raw    = box_q.b - box_q.t + COORD_W'(1);
    assign frame_ok = (box_q.t <= box_q.b) && (box_q.l <= box_q.r) &&
                      (h_raw >= MIN_DIM_C) && (w_raw >= MIN_DIM_C);
    assign step     = (state_q == S_CHECK);

    always_comb begin
        state_d = state_q;
        box_d   = box_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        ovr_d   = ovr_q;
        vld_d   = vld_q;
        row_d   = row_q;
        col_d   = col_q;
        w_d     = w_q;
        h_d     = h_q;
        case (state_q)
            // The first frame boundary both starts the pipeline and is itself captured.
            S_IDLE, S_ACTIVE: begin
                if (fe_q) begin
                    state_d = S_CAPTURE;
                    en_d    = 1'b1;
                    box_d   = {bus.box_t, bus.box_b, bus.box_l, bus.box_r};
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            S_CAPTURE: state_d = S_CHECK;
            S_CHECK: begin
                state_d = S_PUBLISH;
                vld_d   = 1'b1;
                row_d   = frame_ok ? row_ctr : '0;
                col_d   = frame_ok ? col_ctr : '0;
                w_d     = frame_ok ? w_raw   : '0;
                h_d     = frame_ok ? h_raw   : '0;
            end
            S_PUBLISH: begin
                if (fe_q) begin
                    ovr_d = 1'b1;
                    cnt_d = cnt_q + 16'd1;
                end
                if (vld_q && bus.out_ready) begin
                    vld_d   = 1'b0;
                    state_d = S_ACTIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
            fe_q      <= 1'b0;
            state_q   <= S_IDLE;
            box_q     <= '0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            ovr_q     <= 1'b0;
            vld_q     <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            w_q       <= '0;
            h_q       <= '0;
        end else begin
            vs_q      <= vs_n;
            vs_prev_q <= vs_q;
            fe_q      <= vs_prev_q & ~vs_q;
            state_q   <= state_d;
            box_q     <= box_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            ovr_q     <= ovr_d;
            vld_q     <= vld_d;
            row_q     <= row_d;
            col_q     <= col_d;
            w_q       <= w_d;
            h_q       <= h_d;
        end
    end

`ifdef BBOX_AUTO_THRESH_EN
    localparam logic [2*COORD_W-1:0] AREA_QUARTER = (2*COORD_W)'(FRAME_AREA / 4);
    logic [3:0]           sw_q;
    logic [2*COORD_W-1:0] area;

    assign area = w_raw * h_raw;

    // A switch change always wins over the per-frame adaptation.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            thr_q <= threshold_sw;
            sw_q  <= threshold_sw;
        end else begin
            sw_q <= threshold_sw;
            if (threshold_sw != sw_q) begin
                thr_q <= threshold_sw;
            end else if (step) begin
                if (!frame_ok) begin
                    if (thr_q != 4'd0) thr_q <= thr_q - 4'd1;
                end else if ((area > AREA_QUARTER) && (thr_q != 4'd15)) begin
                    thr_q <= thr_q + 4'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        thr_q <= threshold_sw;
    end
`endif

    bbox_lock_filter u_lock (
        .clk    (clk),
        .rstn   (rstn),
        .step   (step),
        .valid  (frame_ok),
        .locked (bus.locked)
    );

    assign en_o          = en_q;
    assign threshold_o   = thr_q;
    assign overrun       = ovr_q;
    assign frame_cnt     = cnt_q;
    assign bus.out_valid = vld_q;
    assign bus.ctr_row   = row_q;
    assign bus.ctr_col   = col_q;
    assign bus.box_w     = w_q;
    assign bus.box_h     = h_q;

endmodule

// File: tb/tb_bbox_frame_ctrl.sv
// Directed frames against a frame-level model of centre/size/lock, checked every cycle.
module tb_bbox_frame_ctrl;

    localparam int CW = bbox_ctrl_pkg::COORD_W;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        vs_n = 1'b1;
    logic [3:0]  threshold_sw = 4'd5;
    logic        en_o;
    logic [3:0]  threshold_o;
    logic        overrun;
    logic [15:0] frame_cnt;

    bbox_frame_ctrl_if bus();

    bbox_frame_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .vs_n         (vs_n),
        .threshold_sw (threshold_sw),
        .en_o         (en_o),
        .threshold_o  (threshold_o),
        .overrun      (overrun),
        .frame_cnt    (frame_cnt),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [CW-1:0] row;
        logic [CW-1:0] col;
        logic [CW-1:0] w;
        logic [CW-1:0] h;
        logic          lk;
    } res_t;

    res_t exp_q[$];
    int   good = 0;
    int   bad = 0;
    bit   m_locked = 1'b0;
    int   exp_frames = 0;
    logic [3:0] sw_prev;
    bit   started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_frame(input int t, input int b, input int l, input int r);
        res_t e;
        bit   ok;
        ok = (t <= b) && (l <= r) && (b - t + 1 >= 4) && (r - l + 1 >= 4);
        e = '0;
        if (ok) begin
            e.row = CW'((t + b) / 2);
            e.col = CW'((l + r) / 2);
            e.w   = CW'(r - l + 1);
            e.h   = CW'(b - t + 1);
            good  = (good < 3) ? good + 1 : 3;
            bad   = 0;
        end else begin
            bad   = (bad < 5) ? bad + 1 : 5;
            good  = 0;
        end
        if (good == 3) m_locked = 1'b1;
        else if (bad == 5) m_locked = 1'b0;
        e.lk = m_locked;
        exp_q.push_back(e);
    endfunction

    always @(posedge clk) begin
        sw_prev <= threshold_sw;
        started <= 1'b1;
    end

    always @(negedge clk) begin
`ifndef BBOX_AUTO_THRESH_EN
        if (started) chk("threshold_follow", threshold_o, sw_prev);
`endif
        if (!rstn) begin
            exp_q.delete();
        end else if (bus.out_valid) begin
            chk("publish_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                chk("ctr_row", bus.ctr_row, exp_q[0].row);
                chk("ctr_col", bus.ctr_col, exp_q[0].col);
                chk("box_w",   bus.box_w,   exp_q[0].w);
                chk("box_h",   bus.box_h,   exp_q[0].h);
                chk("locked",  bus.locked,  exp_q[0].lk);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int t, input int b, input int l, input int r);
        bus.box_t = CW'(t);
        bus.box_b = CW'(b);
        bus.box_l = CW'(l);
        bus.box_r = CW'(r);
        vs_n = 1'b0;
        tick(2);
        vs_n = 1'b1;
        exp_frames++;
    endtask

    task automatic run_frame(input int t, input int b, input int l, input int r);
        model_frame(t, b, l, r);
        pulse(t, b, l, r);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick(1);
        chk("publish_drained", exp_q.size(), 0);
        chk("frame_cnt", frame_cnt, exp_frames);
        tick(4);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 30 && !bus.out_valid; i++) tick(1);
        chk("out_valid_seen", bus.out_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.out_ready = 1'b1;
        bus.box_t = '0;
        bus.box_b = '0;
        bus.box_l = '0;
        bus.box_r = '0;
        tick(3);
        chk("rst_en_o", en_o, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_ctr_row", bus.ctr_row, 0);
        chk("rst_box_w", bus.box_w, 0);
        chk("rst_threshold", threshold_o, 5);
        rstn = 1'b1;
        tick(2);

        // First frame: exact latency and literal results.
        model_frame(100, 199, 300, 419);
        pulse(100, 199, 300, 419);
        tick(2);
        chk("latency_not_early", bus.out_valid, 0);
        tick(1);
        chk("latency_valid", bus.out_valid, 1);
        chk("t1_ctr_row", bus.ctr_row, 149);
        chk("t1_ctr_col", bus.ctr_col, 359);
        chk("t1_box_w", bus.box_w, 120);
        chk("t1_box_h", bus.box_h, 100);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_en_o", en_o, 1);
        tick(3);
        chk("t1_drained", exp_q.size(), 0);

        // Lock acquisition, hysteresis under interleaving, and loss.
        run_frame(10, 60, 20, 80);
        chk("lock_after_2", bus.locked, 0);
        run_frame(30, 90, 40, 70);
        chk("lock_after_3", bus.locked, 1);
        for (int i = 0; i < 2; i++) begin
            run_frame(479, 0, 0, 100);
            run_frame(10, 60, 20, 80);
            chk("interleave_hold_1", bus.locked, 1);
        end
        for (int i = 0; i < 5; i++) begin
            run_frame(479, 0, 0, 100);
            chk("loss_progress", bus.locked, (i == 4) ? 0 : 1);
        end
        for (int i = 0; i < 2; i++) begin
            run_frame(10, 60, 20, 80);
            run_frame(479, 0, 0, 100);
            chk("interleave_hold_0", bus.locked, 0);
        end

        // Minimum-size boundary: 4x4 valid, width 3 and height 1 invalid.
        threshold_sw = 4'd12;
        run_frame(20, 23, 10, 13);
        run_frame(20, 23, 10, 13);
        run_frame(20, 23, 10, 13);
        chk("min_dim_lock", bus.locked, 1);
        for (int i = 0; i < 4; i++) run_frame(0, 50, 10, 12);
        chk("narrow_4_still_locked", bus.locked, 1);
        run_frame(5, 5, 10, 40);
        chk("narrow_5_lost", bus.locked, 0);

        // Backpressure across a frame boundary drops that frame.
        chk("overrun_before", overrun, 0);
        bus.out_ready = 1'b0;
        model_frame(50, 149, 60, 159);
        pulse(50, 149, 60, 159);
        wait_valid();
        pulse(200, 300, 200, 300);
        tick(8);
        chk("ovr_overrun", overrun, 1);
        chk("ovr_valid_held", bus.out_valid, 1);
        chk("ovr_ctr_row", bus.ctr_row, 99);
        chk("ovr_box_w", bus.box_w, 100);
        chk("ovr_frame_cnt", frame_cnt, exp_frames);
        bus.out_ready = 1'b1;
        tick(2);
        chk("ovr_accepted", bus.out_valid, 0);
        run_frame(10, 40, 20, 60);
        chk("overrun_sticky", overrun, 1);

        // Reset while a result is pending.
        for (int i = 0; i < 3; i++) run_frame(100, 199, 300, 419);
        chk("pre_reset_locked", bus.locked, 1);
        bus.out_ready = 1'b0;
        model_frame(100, 199, 300, 419);
        pulse(100, 199, 300, 419);
        wait_valid();
        rstn = 1'b0;
        tick(1);
        chk("rst2_out_valid", bus.out_valid, 0);
        chk("rst2_locked", bus.locked, 0);
        chk("rst2_en_o", en_o, 0);
        chk("rst2_frame_cnt", frame_cnt, 0);
        chk("rst2_overrun", overrun, 0);
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        good = 0;
        bad = 0;
        m_locked = 1'b0;
        exp_frames = 0;
        tick(2);
        run_frame(0, 299, 0, 399);
        chk("post_reset_en_o", en_o, 1);

`ifdef BBOX_AUTO_THRESH_EN
        threshold_sw = 4'd8;
        tick(3);
        chk("auto_reload", threshold_o, 8);
        for (int i = 1; i <= 8; i++) begin
            run_frame(0, 299, 0, 399);
            chk("auto_step_up", threshold_o, (8 + i > 15) ? 15 : 8 + i);
        end
        for (int i = 1; i <= 16; i++) begin
            run_frame(479, 0, 0, 100);
            chk("auto_step_down", threshold_o, (15 - i < 0) ? 0 : 15 - i);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
